// File: rtl/router_pkt_src.sv
// router_pkt_src: buffers one command's payload, then sends header/payload/parity to the 1x3 router and reports err status
// Ports:
//   clk, rst (sync, active-low)
//   cmd_valid/cmd_ready/cmd_addr/cmd_len/cmd_rej : command in, reject pulse out
//   s_valid/s_data/s_ready                       : payload byte stream in
//   busy/err                                     : router handshake and parity error in
//   data_out/pkt_valid                           : router data_in/pkt_valid out
//   done/done_err                                : per-packet completion pulse and error status
module router_pkt_src #(
  parameter int MAX_LEN = 63,
  parameter int ERR_WIN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_addr,
  input  logic [5:0] cmd_len,
  output logic       cmd_rej,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  input  logic       busy,
  input  logic       err,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       done,
  output logic       done_err
);
  typedef enum logic [2:0] {IDLE, FILL, HDR, PLD, PAR, CHK} state_t;
  localparam int WW = ERR_WIN > 1 ? $clog2(ERR_WIN) : 1;
  localparam logic [6:0] MAX_L = 7'(MAX_LEN);
  localparam logic [WW-1:0] WLAST = WW'(ERR_WIN - 1);
  state_t state_q;
  logic [1:0] addr_q;
  logic [5:0] len_q, cnt_q, idx_q;
  logic [7:0] par_q, hdr;
  logic [WW-1:0] wcnt_q;
  logic err_seen_q, cmd_rej_q, done_q, done_err_q, cmd_bad;
  logic [7:0] mem_q [MAX_LEN];
  assign hdr = {len_q, addr_q};
  assign cmd_bad = cmd_addr == 2'd3 || cmd_len == 6'd0 || {1'b0, cmd_len} > MAX_L;
  assign cmd_ready = state_q == IDLE;
  assign s_ready = state_q == FILL;
  assign pkt_valid = state_q == HDR || state_q == PLD;
  assign data_out = state_q == HDR ? hdr : state_q == PLD ? mem_q[idx_q] : state_q == PAR ? par_q : 8'd0;
  assign cmd_rej = cmd_rej_q;
  assign done = done_q;
  assign done_err = done_err_q;
  always_ff @(posedge clk)
    if (state_q == FILL && s_valid) mem_q[cnt_q] <= s_data;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      par_q <= '0;
      wcnt_q <= '0;
      err_seen_q <= 1'b0;
      cmd_rej_q <= 1'b0;
      done_q <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      cmd_rej_q <= 1'b0;
      done_q <= 1'b0;
      done_err_q <= 1'b0;
      case (state_q)
        IDLE: if (cmd_valid) begin
          if (cmd_bad) cmd_rej_q <= 1'b1;
          else begin
            addr_q <= cmd_addr;
            len_q <= cmd_len;
            par_q <= {cmd_len, cmd_addr};
            cnt_q <= '0;
            state_q <= FILL;
          end
        end
        FILL: if (s_valid) begin
          par_q <= par_q ^ s_data;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == len_q - 6'd1) state_q <= HDR;
        end
        HDR: if (!busy) begin
          idx_q <= '0;
          state_q <= PLD;
        end
        PLD: if (!busy) begin
          idx_q <= idx_q + 6'd1;
          if (idx_q == len_q - 6'd1) state_q <= PAR;
        end
        PAR: if (!busy) begin
          wcnt_q <= '0;
          err_seen_q <= 1'b0;
          state_q <= CHK;
        end
        CHK: begin
          err_seen_q <= err_seen_q | err;
          wcnt_q <= wcnt_q + 1'b1;
          if (wcnt_q == WLAST) begin
            done_q <= 1'b1;
            done_err_q <= err_seen_q | err;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_router_pkt_src.sv
// tb_router_pkt_src: randomized self-checking bench for router_pkt_src against a byte-sequence reference model
module tb_router_pkt_src;
  localparam int ERR_WIN = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_rej;
  logic [1:0] cmd_addr = '0;
  logic [5:0] cmd_len = '0;
  logic s_valid = 1'b0, s_ready;
  logic [7:0] s_data = '0;
  logic busy = 1'b0, err = 1'b0;
  logic [7:0] data_out;
  logic pkt_valid, done, done_err;
  int checks = 0, errors = 0;
  logic [7:0] pay[$];
  int stall[66];

  router_pkt_src dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_rej(cmd_rej), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .busy(busy), .err(err), .data_out(data_out), .pkt_valid(pkt_valid), .done(done), .done_err(done_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic fill_rand(input int len);
    pay.delete();
    repeat (len) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic set_stall(input int maxv);
    foreach (stall[i]) stall[i] = $urandom_range(0, maxv);
  endtask

  // wire model: header, payload, XOR parity; stall[k] busy cycles precede consumption of byte k
  task automatic run_pkt(input logic [1:0] a, input int len, input int gap_pct, input int err_at, input int abort_k);
    logic [7:0] exp[$];
    logic [7:0] p;
    int n, guard;
    p = {len[5:0], a};
    exp.push_back(p);
    foreach (pay[i]) begin
      exp.push_back(pay[i]);
      p ^= pay[i];
    end
    exp.push_back(p);
    settle();
    chk("cmd_ready_idle", cmd_ready, 1);
    chk("done_idle", done, 0);
    cmd_valid = 1'b1;
    cmd_addr = a;
    cmd_len = len[5:0];
    tick();
    cmd_valid = 1'b0;
    n = 0;
    guard = 0;
    while (n < len && guard < 2000) begin
      s_valid = $urandom_range(0, 99) >= gap_pct;
      s_data = pay[n];
      settle();
      chk("pv_fill", pkt_valid, 0);
      chk("cmd_ready_fill", cmd_ready, 0);
      if (s_valid && s_ready) n++;
      guard++;
      tick();
    end
    s_valid = 1'b0;
    if (n < len) chk("fill_timeout", n, len);
    for (int k = 0; k < len + 2; k++) begin
      for (int s = 0; s <= stall[k]; s++) begin
        if (k == abort_k && s == 0) begin
          busy = 1'b0;
          rst = 1'b0;
          tick();
          rst = 1'b1;
          settle();
          chk("abort_pv", pkt_valid, 0);
          chk("abort_data", data_out, 0);
          chk("abort_cmd_ready", cmd_ready, 1);
          tick();
          return;
        end
        busy = s < stall[k];
        settle();
        chk("wire_data", data_out, exp[k]);
        chk("wire_pv", pkt_valid, k <= len);
        chk("s_ready_tx", s_ready, 0);
        tick();
      end
    end
    busy = 1'b0;
    for (int c = 1; c <= ERR_WIN + 1; c++) begin
      err = c == err_at;
      settle();
      chk("done", done, c == ERR_WIN + 1);
      chk("cmd_ready_win", cmd_ready, c == ERR_WIN + 1);
      if (c == ERR_WIN + 1) chk("done_err", done_err, err_at >= 1 && err_at <= ERR_WIN);
      tick();
    end
    err = 1'b0;
  endtask

  task automatic reject(input logic [1:0] a, input logic [5:0] l);
    cmd_valid = 1'b1;
    cmd_addr = a;
    cmd_len = l;
    tick();
    cmd_valid = 1'b0;
    settle();
    chk("rej_pulse", cmd_rej, 1);
    chk("rej_s_ready", s_ready, 0);
    chk("rej_pv", pkt_valid, 0);
    chk("rej_cmd_ready", cmd_ready, 1);
    tick();
    settle();
    chk("rej_clear", cmd_rej, 0);
    chk("rej_s_ready2", s_ready, 0);
    tick();
  endtask

  initial begin
    foreach (stall[i]) stall[i] = 0;
    tick();
    tick();
    settle();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_pv", pkt_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_rej", cmd_rej, 0);
    chk("rst_done", {done, done_err}, 0);
    rst = 1'b1;
    tick();
    pay = '{8'h11, 8'h22, 8'h33};
    run_pkt(2'd1, 3, 0, 0, -1);
    stall[0] = 2;
    stall[2] = 4;
    run_pkt(2'd1, 3, 0, 0, -1);
    reject(2'd3, 6'd5);
    reject(2'd0, 6'd0);
    foreach (stall[i]) stall[i] = 0;
    fill_rand(2);
    run_pkt(2'd2, 2, 0, 2, -1);
    fill_rand(2);
    run_pkt(2'd2, 2, 0, 0, -1);
    fill_rand(63);
    set_stall(2);
    run_pkt(2'd0, 63, 40, 0, -1);
    fill_rand(10);
    foreach (stall[i]) stall[i] = 0;
    run_pkt(2'd1, 10, 0, 0, 6);
    fill_rand(1);
    run_pkt(2'd2, 1, 0, 0, -1);
    repeat (8) begin
      int l;
      l = $urandom_range(1, 63);
      fill_rand(l);
      set_stall(2);
      run_pkt(2'($urandom_range(0, 2)), l, $urandom_range(0, 50), $urandom_range(0, 5), -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
